// File: rtl/axi_sram_rd.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_rd
//  Description : AXI4 read-only slave serving AR/R from an on-chip 64-bit
//                SRAM. FIXED/INCR/WRAP bursts, programmable first-beat
//                latency, and a side port for preloading the array.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_rd #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [3:0]            ARID,
    input  logic [63:0]           ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [2:0]            ARPORT,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [3:0]            RID,
    output logic [63:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [63:0]           ld_data
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_WAIT   = 2'd1;
    localparam logic [1:0]  c_ST_BURST  = 2'd2;
    localparam logic [63:0] c_MEM_BYTES = 64'd8 << DEPTH_LOG2;
    localparam logic [3:0]  c_LAT       = 4'(LATENCY);

    logic [63:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]  r_state;
    logic [3:0]  r_id;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_err;
    logic [7:0]  r_beat;
    logic [3:0]  r_lat;

    logic [63:0] w_ar_off;
    logic [63:0] w_ar_last_off;
    logic        w_ar_oor;
    logic        w_ar_wrap_len_ok;
    logic        w_ar_err;
    logic [63:0] w_step;
    logic [63:0] w_mask;
    logic [63:0] w_next_addr;
    logic [63:0] w_beat_addr;
    logic [63:0] w_beat_off;
    logic        w_beat_err;
    logic        w_beat_last;
    logic [3:0]  w_beat_id;
    logic [63:0] w_beat_data;
    logic        w_unused;

    assign ARREADY = rstn && (r_state == c_ST_IDLE);

    // Error classification of the incoming request, evaluated once at acceptance.
    always_comb begin
        w_ar_off         = ARADDR - BASE_ADDR;
        w_ar_oor         = (ARADDR < BASE_ADDR) || (w_ar_off >= c_MEM_BYTES);
        w_ar_last_off    = w_ar_off + ({56'd0, ARLEN} << ARSIZE);
        w_ar_wrap_len_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) ||
                           (ARLEN == 8'd7) || (ARLEN == 8'd15);
        w_ar_err         = w_ar_oor || (ARSIZE > 3'd3) || (ARBURST == 2'b11) ||
                           ((ARBURST == 2'b10) && !w_ar_wrap_len_ok) ||
                           ((ARBURST == 2'b01) && (w_ar_last_off >= c_MEM_BYTES));
    end

    // Next beat address for the latched burst type.
    always_comb begin
        w_step = 64'd1 << r_size;
        w_mask = (({56'd0, r_len} + 64'd1) << r_size) - 64'd1;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~w_mask) | ((r_addr + w_step) & w_mask);
            default: w_next_addr = r_addr + w_step;
        endcase
    end

    // Select the beat about to be loaded: fresh request in IDLE, latched start
    // in WAIT, advanced address in BURST. Reads see pre-preload contents.
    always_comb begin
        w_beat_addr = r_addr;
        w_beat_err  = r_err;
        w_beat_last = (r_len == 8'd0);
        w_beat_id   = r_id;
        case (r_state)
            c_ST_IDLE: begin
                w_beat_addr = ARADDR;
                w_beat_err  = w_ar_err;
                w_beat_last = (ARLEN == 8'd0);
                w_beat_id   = ARID;
            end
            c_ST_BURST: begin
                w_beat_addr = w_next_addr;
                w_beat_last = ((r_beat + 8'd1) == r_len);
            end
            default: ;
        endcase
        w_beat_off  = w_beat_addr - BASE_ADDR;
        w_beat_data = w_beat_err ? 64'd0 : r_mem[w_beat_off[DEPTH_LOG2+2:3]];
    end

    assign w_unused = ^{ARPORT, w_beat_off[63:DEPTH_LOG2+3], w_beat_off[2:0]};

    // Preload port; the array is intentionally not touched by reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Read FSM and registered R channel.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
            r_id    <= 4'd0;
            r_addr  <= 64'd0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'd0;
            r_err   <= 1'b0;
            r_beat  <= 8'd0;
            r_lat   <= 4'd0;
            RID     <= 4'd0;
            RDATA   <= 64'd0;
            RRESP   <= 2'b00;
            RLAST   <= 1'b0;
            RVALID  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        r_id    <= ARID;
                        r_addr  <= ARADDR;
                        r_len   <= ARLEN;
                        r_size  <= ARSIZE;
                        r_burst <= ARBURST;
                        r_err   <= w_ar_err;
                        r_beat  <= 8'd0;
                        if (LATENCY == 0) begin
                            r_state <= c_ST_BURST;
                            RVALID  <= 1'b1;
                            RDATA   <= w_beat_data;
                            RRESP   <= w_beat_err ? 2'b10 : 2'b00;
                            RLAST   <= w_beat_last;
                            RID     <= w_beat_id;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_lat   <= c_LAT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_lat <= r_lat - 4'd1;
                    if (r_lat == 4'd1) begin
                        r_state <= c_ST_BURST;
                        RVALID  <= 1'b1;
                        RDATA   <= w_beat_data;
                        RRESP   <= w_beat_err ? 2'b10 : 2'b00;
                        RLAST   <= w_beat_last;
                        RID     <= w_beat_id;
                    end
                end
                c_ST_BURST: begin
                    if (RREADY) begin
                        if (r_beat == r_len) begin
                            r_state <= c_ST_IDLE;
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_beat <= r_beat + 8'd1;
                            RDATA  <= w_beat_data;
                            RRESP  <= w_beat_err ? 2'b10 : 2'b00;
                            RLAST  <= w_beat_last;
                            RID    <= w_beat_id;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_sram_rd
//  Description : Self-checking bench for axi_sram_rd. Two instances (latency
//                2 and latency 0) share one AR/R stimulus stream; a reference
//                model predicts every beat from the burst rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_rd;

    localparam int          DL   = 6;
    localparam int          NW   = 1 << DL;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] MEMB = 64'(NW * 8);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [3:0]    ARID = '0;
    logic [63:0]   ARADDR = '0;
    logic [7:0]    ARLEN = '0;
    logic [2:0]    ARSIZE = '0;
    logic [1:0]    ARBURST = '0;
    logic [2:0]    ARPORT = '0;
    logic          ARVALID = 1'b0;
    logic          RREADY;
    logic          ld_en = 1'b0;
    logic [DL-1:0] ld_addr = '0;
    logic [63:0]   ld_data = '0;

    logic        arready [2];
    logic [3:0]  rid     [2];
    logic [63:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rlast   [2];
    logic        rvalid  [2];

    axi_sram_rd #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(2)) u_dut_lat2 (
        .clk(clk), .rstn(rstn), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARPORT(ARPORT), .ARVALID(ARVALID),
        .ARREADY(arready[0]), .RID(rid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]),
        .RLAST(rlast[0]), .RVALID(rvalid[0]), .RREADY(RREADY),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    axi_sram_rd #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rstn(rstn), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARPORT(ARPORT), .ARVALID(ARVALID),
        .ARREADY(arready[1]), .RID(rid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]),
        .RLAST(rlast[1]), .RVALID(rvalid[1]), .RREADY(RREADY),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        int          rr;
        bit          err;
    } vec_t;

    beat_t       q [2][$];
    int          hs_cyc [2];
    bit          first_pend [2];
    bit          exp_cont [2];
    bit          exp_idle [2];
    logic [63:0] mm [NW];
    int          total = 0;
    int          bad = 0;
    int          rr_mode = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [63:0] a, input logic [7:0] len,
                                     input logic [2:0] sz, input logic [1:0] bu);
        logic [63:0] off;
        off = a - BASE;
        if (a < BASE || off >= MEMB) return 1'b1;
        if (sz > 3'd3 || bu == 2'b11) return 1'b1;
        if (bu == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (bu == 2'b01 && (off + (64'(len) << sz)) >= MEMB) return 1'b1;
        return 1'b0;
    endfunction

    // Closed-form address of beat i of a burst.
    function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [7:0] len,
                                              input logic [2:0] sz, input logic [1:0] bu, input int i);
        logic [63:0] step;
        logic [63:0] mask;
        step = 64'd1 << sz;
        mask = ((64'(len) + 64'd1) << sz) - 64'd1;
        case (bu)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + 64'(i) * step) & mask);
            default: return a + 64'(i) * step;
        endcase
    endfunction

    function automatic vec_t mk(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                                input logic [1:0] bu, input logic [3:0] id, input int rr, input bit err);
        vec_t v;
        v.addr = a; v.len = len; v.size = sz; v.burst = bu; v.id = id; v.rr = rr; v.err = err;
        return v;
    endfunction

    // RREADY pattern generator: held high, toggling, or random.
    initial begin
        RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       RREADY = 1'b1;
                1:       RREADY = ~RREADY;
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // R-channel monitor: every cycle RVALID is high must show the head of the
    // expected queue; a handshake pops it.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                q[k].delete();
                first_pend[k] = 1'b0;
                exp_cont[k]   = 1'b0;
                exp_idle[k]   = 1'b0;
            end else begin
                int    lat;
                beat_t b;
                lat = (k == 0) ? 2 : 0;
                if (exp_cont[k]) begin
                    check(rvalid[k], $sformatf("back_to_back_u%0d", k), 64'(rvalid[k]), 64'd1);
                    exp_cont[k] = 1'b0;
                end
                if (exp_idle[k]) begin
                    check(!rvalid[k] && arready[k], $sformatf("idle_after_last_u%0d", k),
                          {rvalid[k], arready[k]}, 64'b01);
                    exp_idle[k] = 1'b0;
                end
                if (q[k].size() != 0 && cyc >= hs_cyc[k])
                    check(!arready[k], $sformatf("arready_busy_u%0d", k), 64'(arready[k]), 64'd0);
                if (rvalid[k]) begin
                    if (q[k].size() == 0) begin
                        check(1'b0, $sformatf("spurious_rvalid_u%0d", k), 64'd1, 64'd0);
                    end else begin
                        b = q[k][0];
                        if (first_pend[k]) begin
                            check(cyc == hs_cyc[k] + lat, $sformatf("first_beat_latency_u%0d", k),
                                  64'(cyc - hs_cyc[k]), 64'(lat));
                            first_pend[k] = 1'b0;
                        end
                        check(rdata[k] == b.data, $sformatf("rdata_u%0d", k), rdata[k], b.data);
                        check({rid[k], rresp[k], rlast[k]} == {b.id, b.resp, b.last},
                              $sformatf("rid_rresp_rlast_u%0d", k),
                              {rid[k], rresp[k], rlast[k]}, {b.id, b.resp, b.last});
                        if (RREADY) begin
                            void'(q[k].pop_front());
                            if (b.last) exp_idle[k] = 1'b1;
                            else        exp_cont[k] = 1'b1;
                        end
                    end
                end else if (first_pend[k] && cyc > hs_cyc[k] + lat) begin
                    check(1'b0, $sformatf("first_beat_missing_u%0d", k), 64'(cyc - hs_cyc[k]), 64'(lat));
                    first_pend[k] = 1'b0;
                end
            end
        end
    end

    // Issue one AR to both instances (called at a negedge); force_err<0 uses the model.
    task automatic start_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [3:0] id, input int force_err);
        bit          err;
        int          n;
        beat_t       b;
        logic [63:0] ba;
        n = 0;
        err = (force_err >= 0) ? (force_err != 0) : model_err(a, len, sz, bu);
        while (!(arready[0] && arready[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(arready[0] && arready[1], "arready_wait", {arready[0], arready[1]}, 64'b11);
        for (int i = 0; i <= int'(len); i++) begin
            ba     = beat_addr(a, len, sz, bu, i) - BASE;
            b.data = err ? 64'd0 : mm[ba[DL+2:3]];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            b.id   = id;
            q[0].push_back(b);
            q[1].push_back(b);
        end
        ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARID = id;
        ARPORT = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hs_cyc[k]     = cyc + 1;
            first_pend[k] = 1'b1;
        end
        @(negedge clk);
        ARVALID = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(q[0].size() == 0 && q[1].size() == 0, "burst_timeout",
              64'(q[0].size() + q[1].size()), 64'd0);
        q[0].delete();
        q[1].delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t        vecs[$];
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int          n;

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check(!arready[k] && !rvalid[k] && !rlast[k] && rid[k] == 4'd0 &&
                  rdata[k] == 64'd0 && rresp[k] == 2'b00, $sformatf("reset_state_u%0d", k),
                  {arready[k], rvalid[k], rlast[k], rid[k], rresp[k], rdata[k][49:0]}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check(arready[0] && arready[1], "arready_after_reset", {arready[0], arready[1]}, 64'b11);

        // Preload the whole array through the side port.
        for (int w = 0; w < NW; w++) begin
            ld_en   = 1'b1;
            ld_addr = DL'(w);
            ld_data = (w == 0) ? 64'h0000_0013_0000_0297 : {$urandom, $urandom};
            mm[w]   = ld_data;
            @(negedge clk);
        end
        ld_en = 1'b0;
        @(negedge clk);

        //           addr                len  sz  burst  id   rr  err
        vecs.push_back(mk(BASE + 64'h000, 0,  2, 2'b01, 4'h5, 0, 0)); // single read, word 0
        vecs.push_back(mk(BASE + 64'h010, 3,  3, 2'b01, 4'h3, 1, 0)); // words 2..5, RREADY toggling
        vecs.push_back(mk(BASE + 64'h018, 3,  3, 2'b10, 4'h9, 0, 0)); // WRAP: words 3,0,1,2
        vecs.push_back(mk(64'h1000,       1,  3, 2'b01, 4'h1, 0, 1)); // below base
        vecs.push_back(mk(BASE + 64'h008, 7,  3, 2'b01, 4'h2, 0, 0)); // 8-beat INCR
        vecs.push_back(mk(BASE + 64'h020, 2,  3, 2'b00, 4'hC, 0, 0)); // FIXED, word 4 x3
        vecs.push_back(mk(BASE + 64'h000, 0,  4, 2'b01, 4'h4, 0, 1)); // size > 3
        vecs.push_back(mk(BASE + 64'h040, 1,  3, 2'b11, 4'h6, 0, 1)); // reserved burst
        vecs.push_back(mk(BASE + 64'h040, 2,  3, 2'b10, 4'h7, 0, 1)); // WRAP with len 2
        vecs.push_back(mk(BASE + 64'h1F8, 1,  3, 2'b01, 4'h8, 0, 1)); // INCR crosses top
        vecs.push_back(mk(BASE + 64'h1F8, 0,  3, 2'b01, 4'hA, 0, 0)); // last word, legal
        vecs.push_back(mk(BASE + 64'h200, 0,  3, 2'b01, 4'hB, 0, 1)); // one past top
        vecs.push_back(mk(BASE - 64'h8,   0,  3, 2'b01, 4'hD, 0, 1)); // just below base
        vecs.push_back(mk(BASE + 64'h003, 3,  0, 2'b01, 4'hE, 1, 0)); // narrow bytes in word 0
        vecs.push_back(mk(BASE + 64'h0F0, 15, 3, 2'b10, 4'hF, 2, 0)); // 16-beat WRAP
        for (int i = 0; i < vecs.size(); i++) begin
            rr_mode = vecs[i].rr;
            start_ar(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id,
                     vecs[i].err ? 1 : 0);
            wait_done();
        end

        // Randomized requests against the model's error rules.
        rr_mode = 2;
        for (int t = 0; t < 40; t++) begin
            ra = BASE - 64'd16 + 64'($urandom_range(0, 544));
            rs = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            rb = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (rb == 2'b10)
                rl = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'((2 << $urandom_range(0, 3)) - 1);
            else
                rl = 8'($urandom_range(0, 15));
            start_ar(ra, rl, rs, rb, 4'($urandom_range(0, 15)), -1);
            wait_done();
        end

        // Reset in the middle of a 4-beat burst.
        rr_mode = 0;
        repeat (2) @(negedge clk);
        start_ar(BASE + 64'h040, 3, 3, 2'b01, 4'hA, 0);
        n = 0;
        while (q[0].size() > 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(q[0].size() == 3, "reset_seq_first_beat", 64'(q[0].size()), 64'd3);
        rstn = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check(!rvalid[k] && !rlast[k] && !arready[k], $sformatf("abort_outputs_u%0d", k),
                  {rvalid[k], rlast[k], arready[k]}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check(arready[0] && arready[1], "arready_after_abort", {arready[0], arready[1]}, 64'b11);
        start_ar(BASE + 64'h100, 1, 3, 2'b01, 4'h7, 0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
